// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined IEEE-754 multiplier with RISC-V rounding, specials, flags and valid/ready stall/flush.
// Operands are registered on acceptance, then unpack, multiply, normalise and round/pack stages follow.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [4:0]       out_flags,
    output logic [TAG_W-1:0] out_tag
);
    localparam int EW = EXP_W + 2;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam int MT = 10 + TAG_W + W;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EXP_W-1:0] EMAX_M1 = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EW-1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [EW-1:0] E_OVF = {2'b00, EMAX};
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    logic             advance;
    logic             v0_q, v1_q, v2_q, v3_q, out_valid_q;
    logic [W-1:0]     a0_q, b0_q;
    logic [2:0]       rm0_q;
    logic [TAG_W-1:0] tag0_q;
    logic [MT-1:0]    m1_d, m1_q, m2_q, m3_q;
    logic [EW-1:0]    e1_d, e1_q, e2_q, e3_d, e3_q, e_rnd;
    logic [MW-1:0]    ma1_q, mb1_q, mant;
    logic [PW-1:0]    p2_q;
    logic [PW-2:0]    nsh;
    logic [MAN_W-1:0] f3_q;
    logic             g3_q, st3_q;
    logic [W-1:0]     out_result_q, res_d;
    logic [4:0]       out_flags_q, flg_d;
    logic [TAG_W-1:0] out_tag_q;

    assign advance = !out_valid_q | out_ready;
    assign in_ready = advance;
    assign out_valid = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags = out_flags_q;
    assign out_tag = out_tag_q;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             za, zb, ia, ib, na, nb, inv, nan, sgn1;
    assign ea = a0_q[W-2:MAN_W];
    assign eb = b0_q[W-2:MAN_W];
    assign fa = a0_q[MAN_W-1:0];
    assign fb = b0_q[MAN_W-1:0];
    assign za = ea == '0;
    assign zb = eb == '0;
    assign ia = ea == EMAX && fa == '0;
    assign ib = eb == EMAX && fb == '0;
    assign na = ea == EMAX && fa != '0;
    assign nb = eb == EMAX && fb != '0;
    assign inv = (ia & zb) | (ib & za);
    assign nan = na | nb | inv;
    assign sgn1 = a0_q[W-1] ^ b0_q[W-1];
    // Metadata bundle: {sign, rm, tag, special, special result, special flags}
    assign m1_d = {sgn1, rm0_q, tag0_q, nan | ia | ib | za | zb,
                   nan ? QNAN : (ia | ib) ? {sgn1, EMAX, {MAN_W{1'b0}}} : {sgn1, {(W-1){1'b0}}},
                   (na & !fa[MAN_W-1]) | (nb & !fb[MAN_W-1]) | inv, 4'b0000};
    assign e1_d = {2'b00, ea} + {2'b00, eb} - BIAS;

    assign nsh = p2_q[PW-1] ? p2_q[PW-2:0] : {p2_q[PW-3:0], 1'b0};
    assign e3_d = e2_q + {{(EW-1){1'b0}}, p2_q[PW-1]};

    logic             sgn4, sp4, gs, inc, ovf, unf, ovf_inf;
    logic [2:0]       rm4;
    logic [TAG_W-1:0] tag4;
    logic [W-1:0]     spres4;
    logic [4:0]       spflg4;
    assign {sgn4, rm4, tag4, sp4, spres4, spflg4} = m3_q;
    assign gs = g3_q | st3_q;
    assign inc = rm4 == 3'd1 ? 1'b0 : rm4 == 3'd2 ? gs & sgn4 : rm4 == 3'd3 ? gs & !sgn4 :
                 rm4 == 3'd4 ? g3_q : g3_q & (st3_q | f3_q[0]);
    assign mant = {1'b0, f3_q} + {{MAN_W{1'b0}}, inc};
    assign e_rnd = e3_q + {{(EW-1){1'b0}}, mant[MAN_W]};
    assign ovf = !e_rnd[EW-1] && e_rnd >= E_OVF;
    assign unf = e_rnd[EW-1] || e_rnd == '0;
    assign ovf_inf = rm4 == 3'd1 ? 1'b0 : rm4 == 3'd2 ? sgn4 : rm4 == 3'd3 ? !sgn4 : 1'b1;
    assign res_d = sp4 ? spres4 :
                   ovf ? (ovf_inf ? {sgn4, EMAX, {MAN_W{1'b0}}} : {sgn4, EMAX_M1, {MAN_W{1'b1}}}) :
                   unf ? {sgn4, {(W-1){1'b0}}} : {sgn4, e_rnd[EXP_W-1:0], mant[MAN_W-1:0]};
    assign flg_d = sp4 ? spflg4 : ovf ? 5'b00101 : unf ? 5'b00011 : {4'b0000, gs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {v0_q, v1_q, v2_q, v3_q, out_valid_q} <= '0;
            out_result_q <= '0;
            out_flags_q <= '0;
            out_tag_q <= '0;
        end else if (flush) begin
            {v0_q, v1_q, v2_q, v3_q, out_valid_q} <= '0;
        end else if (advance) begin
            {v0_q, v1_q, v2_q, v3_q, out_valid_q} <= {in_valid, v0_q, v1_q, v2_q, v3_q};
            out_result_q <= res_d;
            out_flags_q <= flg_d;
            out_tag_q <= tag4;
        end
    end

    // Datapath needs no reset: stage valids gate everything observable
    always_ff @(posedge clk) begin
        if (advance) begin
            a0_q <= in_a;
            b0_q <= in_b;
            rm0_q <= in_rm;
            tag0_q <= in_tag;
            m1_q <= m1_d;
            e1_q <= e1_d;
            ma1_q <= {1'b1, fa};
            mb1_q <= {1'b1, fb};
            m2_q <= m1_q;
            e2_q <= e1_q;
            p2_q <= {{MW{1'b0}}, ma1_q} * {{MW{1'b0}}, mb1_q};
            m3_q <= m2_q;
            e3_q <= e3_d;
            f3_q <= nsh[PW-2 -: MAN_W];
            g3_q <= nsh[PW-2-MAN_W];
            st3_q <= |nsh[PW-3-MAN_W:0];
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed single-precision vectors, latency, stall, flush and reset checks for fp_mul_pipe.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [2:0]  in_rm;
    logic [4:0]  in_tag, out_tag, out_flags;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] va [6] = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h7F800000, 32'hFF800000};
    logic [31:0] vb [6] = '{32'h40000000, 32'h3F800001, 32'h7F000000, 32'h3F000000, 32'h00000000, 32'h40000000};
    logic [31:0] vr [6] = '{32'h40400000, 32'h3F800002, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000};

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_rm(in_rm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag)
    );

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                          input logic [4:0] tag, input logic [31:0] er, input logic [4:0] ef);
        int lat = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_rm = rm;
        in_tag = tag;
        out_ready = 1'b1;
        #1 chk({nm, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, 4);
        chk({nm, " result"}, out_result, er);
        chk({nm, " flags"}, out_flags, ef);
        chk({nm, " tag"}, out_tag, tag);
    endtask

    task automatic watch_quiet(input string nm);
        int stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk(nm, stray, 0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_rm = '0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_result", out_result, 0);
        chk("reset out_flags", out_flags, 0);
        chk("reset out_tag", out_tag, 0);
        chk("reset in_ready", in_ready, 1);
        rst = 1'b0;

        run_op("1.5x2 rne", 32'h3FC00000, 32'h40000000, 3'd0, 5'd7, 32'h40400000, 5'h00);
        run_op("ulp rne", 32'h3F800001, 32'h3F800001, 3'd0, 5'd1, 32'h3F800002, 5'h01);
        run_op("ulp rup", 32'h3F800001, 32'h3F800001, 3'd3, 5'd2, 32'h3F800003, 5'h01);
        run_op("ulp rtz", 32'h3F800001, 32'h3F800001, 3'd1, 5'd3, 32'h3F800002, 5'h01);
        run_op("ulp rmm", 32'h3F800001, 32'h3F800001, 3'd4, 5'd4, 32'h3F800002, 5'h01);
        run_op("ovf rne", 32'h7F000000, 32'h7F000000, 3'd0, 5'd5, 32'h7F800000, 5'h05);
        run_op("ovf rtz", 32'h7F000000, 32'h7F000000, 3'd1, 5'd6, 32'h7F7FFFFF, 5'h05);
        run_op("ovf rdn neg", 32'hFF000000, 32'h7F000000, 3'd2, 5'd8, 32'hFF800000, 5'h05);
        run_op("ovf rup neg", 32'hFF000000, 32'h7F000000, 3'd3, 5'd9, 32'hFF7FFFFF, 5'h05);
        run_op("ovf rm7", 32'h7F000000, 32'h7F000000, 3'd7, 5'd10, 32'h7F800000, 5'h05);
        run_op("underflow", 32'h00800000, 32'h3F000000, 3'd0, 5'd11, 32'h00000000, 5'h03);
        run_op("inf x 0", 32'h7F800000, 32'h00000000, 3'd0, 5'd12, 32'h7FC00000, 5'h10);
        run_op("snan", 32'h7F800001, 32'h3F800000, 3'd0, 5'd13, 32'h7FC00000, 5'h10);
        run_op("qnan", 32'h7FC00000, 32'h3F800000, 3'd0, 5'd14, 32'h7FC00000, 5'h00);
        run_op("-inf x 2", 32'hFF800000, 32'h40000000, 3'd0, 5'd15, 32'hFF800000, 5'h00);
        run_op("-0 x 2", 32'h80000000, 32'h40000000, 3'd0, 5'd16, 32'h80000000, 5'h00);

        begin
            int sent = 0, got = 0, stall = 0;
            bit seen = 0;
            for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
                @(negedge clk);
                in_valid = sent < 6;
                in_a = va[sent < 6 ? sent : 0];
                in_b = vb[sent < 6 ? sent : 0];
                in_rm = 3'd0;
                in_tag = 5'(10 + sent);
                if (out_valid && !seen) begin
                    seen = 1;
                    stall = 3;
                end
                out_ready = stall == 0;
                #1;
                if (stall > 0) begin
                    chk("b2b stall in_ready", in_ready, 0);
                    chk("b2b stall hold", out_result, vr[got]);
                    stall--;
                end
                if (out_valid && out_ready) begin
                    chk("b2b result", out_result, vr[got]);
                    chk("b2b tag", out_tag, 10 + got);
                    got++;
                end
                if (in_valid && in_ready) sent++;
            end
            chk("b2b count", got, 6);
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            watch_quiet("b2b no duplicate");
        end

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = va[i];
            in_b = vb[i];
            in_rm = 3'd0;
            in_tag = 5'(20 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        chk("rst pre valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst async out_valid", out_valid, 0);
        chk("rst async out_result", out_result, 0);
        chk("rst async out_tag", out_tag, 0);
        chk("rst in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        watch_quiet("rst no stale");
        run_op("after rst", 32'h3FC00000, 32'h40000000, 3'd0, 5'd30, 32'h40400000, 5'h00);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = va[i];
            in_b = vb[i];
            in_tag = 5'(24 + i);
        end
        @(negedge clk);
        flush = 1'b1;
        in_a = va[3];
        in_b = vb[3];
        in_tag = 5'd27;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush out_valid", out_valid, 0);
        watch_quiet("flush no stale");
        run_op("after flush", 32'h3F800001, 32'h3F800001, 3'd3, 5'd31, 32'h3F800003, 5'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
